uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Four-requester round-robin arbiter feeding a single 8N1 UART transmitter.
// Grant takes one cycle; frames run back-to-back with no gap; REQ is sampled only in IDLE and the last STOP cycle.
module uart_tx_arbiter #(
  parameter int CLK_HZ   = 12_000_000,
  parameter int BIT_RATE = 9600
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [3:0]  REQ,
  input  logic [31:0] DATA,
  output logic [3:0]  ACK,
  output logic [1:0]  GRANT_ID,
  output logic        BUSY,
  output logic        TX
);

  localparam int CPB   = CLK_HZ / BIT_RATE;
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       byte_q;
  logic [1:0]       ptr;
  logic             last;
  logic             arb_pt;
  logic             gnt_vld;
  logic [1:0]       gnt_idx;

  assign last   = (cnt == CNT_W'(CPB - 1));
  assign arb_pt = (state == ST_IDLE) || (state == ST_STOP && last);

  // Search from the farthest offset down so the nearest requester to ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (REQ[ptr + 2'(k)]) begin
        gnt_vld = 1'b1;
        gnt_idx = ptr + 2'(k);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_idx  <= 3'd0;
      byte_q   <= 8'd0;
      ptr      <= 2'd0;
      ACK      <= 4'd0;
      GRANT_ID <= 2'd0;
      BUSY     <= 1'b0;
      TX       <= 1'b1;
    end else begin
      ACK <= 4'd0;
      if (arb_pt && gnt_vld) begin
        state    <= ST_START;
        cnt      <= '0;
        bit_idx  <= 3'd0;
        byte_q   <= DATA[{gnt_idx, 3'b000} +: 8];
        ptr      <= gnt_idx + 2'd1;
        ACK      <= 4'b0001 << gnt_idx;
        GRANT_ID <= gnt_idx;
        BUSY     <= 1'b1;
        TX       <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            BUSY <= 1'b0;
            TX   <= 1'b1;
          end
          ST_START: begin
            if (last) begin
              cnt     <= '0;
              bit_idx <= 3'd0;
              state   <= ST_DATA;
              TX      <= byte_q[0];
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_DATA: begin
            if (last) begin
              cnt <= '0;
              if (bit_idx == 3'd7) begin
                state <= ST_STOP;
                TX    <= 1'b1;
              end else begin
                bit_idx <= bit_idx + 3'd1;
                TX      <= byte_q[bit_idx + 3'd1];
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_STOP: begin
            if (last) begin
              cnt   <= '0;
              state <= ST_IDLE;
              BUSY  <= 1'b0;
              TX    <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
            BUSY  <= 1'b0;
            TX    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
